imem_line_responder: RTL

IMEM_LINE_RESPONDER -- requirements
Module: imem_line_responder

---
 rtl/imem_line_responder_pkg.sv | 28 ++
 rtl/imem_line_responder.sv | 125 ++++++++++++
 2 files changed

// File: rtl/imem_line_responder_pkg.sv
// Shared instruction-cache definitions used by the line responder.
//   ICACHE_LINE_WIDTH        : bits per cache line
//   type_icache2mem_s        : refill request (level req + byte address)
//   type_mem2icache_s        : refill response (line data + 1-cycle ack)
//   type_imem_resp_states_e  : line responder FSM states
package imem_line_responder_pkg;

  localparam int ICACHE_LINE_WIDTH = 128;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } type_icache2mem_s;

  typedef struct packed {
    logic [ICACHE_LINE_WIDTH-1:0] r_data;
    logic                         ack;
  } type_mem2icache_s;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } type_imem_resp_states_e;

endpackage

// File: rtl/imem_line_responder.sv
// Instruction memory line responder: turns an icache line-refill request into
// LINE_WORDS consecutive word reads of a 1-cycle-latency SRAM, assembles the
// line and returns it with a single-cycle ack.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   imem_sel_i     : instruction memory selected (requests ignored when low)
//   icache2mem_i   : request (.req level, .addr byte address)
//   mem2icache_o   : response (.r_data line, .ack pulse)
//   sram_req_o     : SRAM word-read strobe
//   sram_addr_o    : SRAM word address
//   sram_rdata_i   : SRAM read data, one cycle after sram_req_o
module imem_line_responder
  import imem_line_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int LINE_WORDS  = ICACHE_LINE_WIDTH / 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             imem_sel_i,
  input  type_icache2mem_s icache2mem_i,
  output type_mem2icache_s mem2icache_o,
  output logic             sram_req_o,
  output logic [29:0]      sram_addr_o,
  input  logic [31:0]      sram_rdata_i
);

  localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [BW:0] LAST_BEAT = (BW+1)'(LINE_WORDS - 1);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  // Word-address mask that clears the word-in-line offset.
  localparam logic [29:0] LINE_MASK = ~30'(LINE_WORDS - 1);

  type_imem_resp_states_e state_q, state_d;
  logic [BW:0]                  beat_q, beat_d;
  logic [3:0]                   wait_q, wait_d;
  logic [29:0]                  base_q, base_d;
  logic [LINE_WORDS-1:0][31:0]  line_q, line_d;
  logic [ICACHE_LINE_WIDTH-1:0] r_data_q, r_data_d;
  logic                         cap_vld_q, cap_vld_d;
  logic [BW-1:0]                cap_idx_q, cap_idx_d;

  logic go;
  logic unused_addr_lsb;

  assign go              = icache2mem_i.req & imem_sel_i;
  assign unused_addr_lsb = ^icache2mem_i.addr[1:0];

  // Strobe is gated combinationally so an abort drops it in the same cycle.
  assign sram_req_o  = (state_q == READ) & go;
  // Base is line-aligned, so OR-ing the beat index can never leave the line.
  assign sram_addr_o = base_q | 30'(beat_q);

  assign mem2icache_o.ack    = (state_q == RESP);
  assign mem2icache_o.r_data = r_data_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    base_d    = base_q;
    line_d    = line_q;
    r_data_d  = r_data_q;
    cap_vld_d = sram_req_o;
    cap_idx_d = beat_q[BW-1:0];

    // Words are staged in line_q; r_data only changes when a full line lands,
    // so an aborted refill leaves the previous line visible.
    if (cap_vld_q) line_d[cap_idx_q] = sram_rdata_i;

    case (state_q)
      IDLE: begin
        if (go) begin
          base_d  = icache2mem_i.addr[31:2] & LINE_MASK;
          beat_d  = '0;
          wait_d  = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? WAIT : READ;
        end
      end
      WAIT: begin
        if (!go)              state_d = IDLE;
        else if (wait_q == 0) state_d = READ;
        else                  wait_d  = wait_q - 4'd1;
      end
      READ: begin
        if (!go)                     state_d = IDLE;
        else if (beat_q == LAST_BEAT) state_d = DRAIN;
        else                         beat_d  = beat_q + 1'b1;
      end
      DRAIN: begin
        if (!go) begin
          state_d = IDLE;
        end else begin
          r_data_d = ICACHE_LINE_WIDTH'(line_d);
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      wait_q    <= '0;
      base_q    <= '0;
      line_q    <= '0;
      r_data_q  <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
      base_q    <= base_d;
      line_q    <= line_d;
      r_data_q  <= r_data_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
    end
  end

endmodule
